// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// start/busy/done handshake and a direct write port into the register bank.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [4:0]       rdIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       writePort,
    output logic             regWrite
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [4:0]         rd_q;
    logic [4:0]         cnt_q;
    logic               negA_q, negB_q;
    logic [WIDTH-1:0]   const_q;
    logic [2*WIDTH-1:0] work_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         writePort_q;
    logic               busy_q, done_q, regWrite_q;

    logic               signedA, signedB, negA, negB;
    logic               isDiv, divZero, divOvf, special;
    logic [WIDTH-1:0]   magA, magB, specialRes;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext, divNext, workNext_d, prodFix;
    logic [WIDTH:0]     remShift;
    logic               divGe;
    logic [WIDTH-1:0]   divDiff, quoFix, remFix, final_d;

    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

    // Operand conditioning: which sources are treated as signed, their magnitudes,
    // and the divide cases that bypass iteration entirely.
    assign signedA    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign signedB    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign negA       = signedA & busA[WIDTH-1];
    assign negB       = signedB & busB[WIDTH-1];
    assign magA       = negA ? -busA : busA;
    assign magB       = negB ? -busB : busB;
    assign isDiv      = funct3[2];
    assign divZero    = isDiv && (busB == '0);
    assign divOvf     = isDiv && !funct3[0] && (busA == MinInt) && (busB == '1);
    assign special    = divZero || divOvf;
    assign specialRes = divZero ? (funct3[1] ? busA : '1) : (funct3[1] ? '0 : MinInt);

    // One iteration of either shift-add multiply or restoring divide, plus the
    // sign-corrected, op-selected result that is captured when iteration ends.
    always_comb begin
        mulSum     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, const_q} : '0);
        mulNext    = {mulSum, work_q[WIDTH-1:1]};
        remShift   = work_q[2*WIDTH-1:WIDTH-1];
        divGe      = remShift >= {1'b0, const_q};
        divDiff    = remShift[WIDTH-1:0] - const_q;
        divNext    = divGe ? {divDiff, work_q[WIDTH-2:0], 1'b1}
                           : {work_q[2*WIDTH-2:0], 1'b0};
        workNext_d = op_q[2] ? divNext : mulNext;
        prodFix    = (negA_q ^ negB_q) ? -workNext_d : workNext_d;
        quoFix     = (negA_q ^ negB_q) ? -workNext_d[WIDTH-1:0] : workNext_d[WIDTH-1:0];
        remFix     = negA_q ? -workNext_d[2*WIDTH-1:WIDTH] : workNext_d[2*WIDTH-1:WIDTH];
        final_d    = remFix;
        case (op_q)
            3'b000:                 final_d = prodFix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_d = prodFix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_d = quoFix;
            default:                final_d = remFix;
        endcase
    end

    // Control FSM with registered handshake and write-port outputs; busy stays
    // high through the done cycle so a start there is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            negA_q      <= 1'b0;
            negB_q      <= 1'b0;
            const_q     <= '0;
            work_q      <= '0;
            res_q       <= '0;
            result_q    <= '0;
            writePort_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            regWrite_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            regWrite_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !busy_q) begin
                        op_q    <= funct3;
                        rd_q    <= rdIn;
                        cnt_q   <= '0;
                        negA_q  <= negA;
                        negB_q  <= negB;
                        busy_q  <= 1'b1;
                        const_q <= isDiv ? magB : magA;
                        work_q  <= {{WIDTH{1'b0}}, (isDiv ? magA : magB)};
                        if (special) begin
                            res_q   <= specialRes;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CALC: begin
                    work_q <= workNext_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH-1)) begin
                        res_q   <= final_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    result_q    <= res_q;
                    writePort_q <= rd_q;
                    done_q      <= 1'b1;
                    regWrite_q  <= (rd_q != 5'd0);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign writePort = writePort_q;
    assign regWrite  = regWrite_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: reference-model bench for muldiv_unit.
// A latency-level model tracks expected handshake outputs every cycle and an
// arithmetic reference computes each result from plain 64-bit math.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] busA = 32'd0;
    logic [31:0] busB = 32'd0;
    logic [4:0]  rdIn = 5'd0;
    logic        busy, done, regWrite;
    logic [31:0] result;
    logic [4:0]  writePort;

    int total = 0;
    int bad   = 0;

    logic        mBusy = 1'b0, mDone = 1'b0, mRegWrite = 1'b0, mDraining = 1'b0;
    logic [31:0] mResult = 32'd0, pendRes = 32'd0;
    logic [4:0]  mWp = 5'd0, pendRd = 5'd0;
    int          mLeft = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .busA(busA), .busB(busB), .rdIn(rdIn),
        .busy(busy), .done(done), .result(result),
        .writePort(writePort), .regWrite(regWrite)
    );

    always #5 clk = ~clk;

    // Architectural result of one RV32M op from signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic isSpecial(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return !f[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] randOp();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        start  = 1'b1;
        funct3 = f;
        busA   = a;
        busB   = b;
        rdIn   = rd;
    endtask

    task automatic applyJunk();
        applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // Waits (bounded) from the cycle after acceptance until done is seen.
    task automatic waitDone(input string name, output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic doOp(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] expRes, input int expLat);
        int lat;
        @(negedge clk);
        applyStimulus(f, a, b, rd);
        @(negedge clk);
        start = 1'b0;
        waitDone(name, lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_res"}, result, expRes);
        checkOutput({name, "_wp"}, 32'(writePort), 32'(rd));
        checkOutput({name, "_rw"}, 32'(regWrite), 32'(rd != 5'd0));
        @(negedge clk);
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Cycle-level expectation: accept when idle, done a fixed latency later,
    // busy released one cycle after done; reset aborts everything.
    always @(posedge clk) begin
        if (reset) begin
            mBusy = 1'b0; mDone = 1'b0; mRegWrite = 1'b0; mDraining = 1'b0;
            mResult = 32'd0; mWp = 5'd0; mLeft = 0;
        end else begin
            mDone = 1'b0;
            mRegWrite = 1'b0;
            if (!mBusy) begin
                if (start) begin
                    mBusy   = 1'b1;
                    pendRes = refResult(funct3, busA, busB);
                    pendRd  = rdIn;
                    mLeft   = isSpecial(funct3, busA, busB) ? 1 : 33;
                end
            end else if (mDraining) begin
                mBusy = 1'b0;
                mDraining = 1'b0;
            end else begin
                mLeft--;
                if (mLeft == 0) begin
                    mDone = 1'b1;
                    mResult = pendRes;
                    mWp = pendRd;
                    mRegWrite = (pendRd != 5'd0);
                    mDraining = 1'b1;
                end
            end
        end
    end

    // Every cycle, all outputs against the model.
    always @(negedge clk) begin
        checkOutput("cyc_busy", 32'(busy), 32'(mBusy));
        checkOutput("cyc_done", 32'(done), 32'(mDone));
        checkOutput("cyc_regWrite", 32'(regWrite), 32'(mRegWrite));
        checkOutput("cyc_result", result, mResult);
        checkOutput("cyc_writePort", 32'(writePort), 32'(mWp));
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, doneCnt;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_wp", 32'(writePort), 32'd0);
        checkOutput("rst_rw", 32'(regWrite), 32'd0);
        reset = 1'b0;

        checkOutput("model_mulh", refResult(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
        checkOutput("model_div", refResult(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        checkOutput("model_rem", refResult(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        doOp("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        doOp("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 33);
        doOp("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);
        doOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33);
        doOp("div",    3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33);
        doOp("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33);
        doOp("divu",   3'd5, 32'd100, 32'd7, 5'd7, 32'h0000000E, 33);
        doOp("remu",   3'd7, 32'd100, 32'd7, 5'd8, 32'h00000002, 33);
        doOp("div0",   3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1);
        doOp("remu0",  3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        doOp("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        doOp("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1);
        doOp("rdzero", 3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 33);

        // start held high across the whole operation, including the done cycle
        @(negedge clk);
        applyStimulus(3'd0, 32'd5, 32'd6, 5'd3);
        doneCnt = 0;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (done) doneCnt++;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("hold_donecnt", 32'(doneCnt), 32'd1);
        checkOutput("hold_res", result, 32'd30);

        // second start mid-operation must not disturb the first
        @(negedge clk);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd9);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(3'd0, 32'd3, 32'd3, 5'd4);
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore", lat);
        checkOutput("ignore_res", result, 32'd14);
        checkOutput("ignore_wp", 32'(writePort), 32'd9);
        @(negedge clk);

        // reset during CALC aborts the operation
        @(negedge clk);
        applyStimulus(3'd0, 32'd9, 32'd9, 5'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_rw", 32'(regWrite), 32'd0);
        checkOutput("abort_res", result, 32'd0);
        reset = 1'b0;
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort_nodone", 32'(doneCnt), 32'd0);
        doOp("after_abort", 3'd0, 32'd3, 32'd4, 5'd2, 32'h0000000C, 33);

        // randomized operations with spurious starts while busy
        for (int i = 0; i < 60; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = randOp();
            b  = randOp();
            rd = 5'($urandom_range(0, 31));
            @(negedge clk);
            applyStimulus(f, a, b, rd);
            @(negedge clk);
            start = 1'b0;
            lat = 0;
            while (!done && lat < 60) begin
                if ($urandom_range(0, 3) == 0) applyJunk();
                else start = 1'b0;
                @(negedge clk);
                lat++;
            end
            checkOutput("rand_done", 32'(done), 32'd1);
            checkOutput("rand_res", result, refResult(f, a, b));
            if ($urandom_range(0, 1) == 1) applyJunk();
            else start = 1'b0;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
